pwm_duty_sequencer: RTL and testbench
=====================================

Name: pwm_duty_sequencer

Overview:
Controller that sequences the PWM signal generator's duty-step inputs (xu/xd). It accepts a target duty step, then issues single-cycle xu or xd pulses with a programmable gap until the generator's duty matches the target. It keeps a mirror of the generator's current step count and signals completion. It sits between the control/register logic and the generator's xu/xd pins and drives the same ena.

Parameters:
MAX_STEP, 10, highest duty step the generator supports (step 0..MAX_STEP)
RESET_STEP, 5, mirror value after reset; must equal the generator's own reset duty step
GAP_W, 8, width of gap input

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
ena  input  1  high = run; low = freeze all state, no pulses
load  input  1  one-cycle strobe; latch target
target  input  4  requested duty step; values above MAX_STEP saturate to MAX_STEP
gap  input  GAP_W  idle cycles between consecutive step pulses; 0 is treated as 1
xu  output  1  one-cycle increment pulse to the generator
xd  output  1  one-cycle decrement pulse to the generator
busy  output  1  high while the mirror is not equal to the latched target, or while homing
cur_step  output  4  mirror of the generator's duty step
done  output  1  one-cycle pulse when the mirror reaches the target

Behaviour:
- Reset (rst=1 at a clock edge) has priority over everything.
  - State = IDLE; tgt = cur_step = RESET_STEP.
  - xu = xd = done = busy = 0; gap counter = 0.
  - Applies mid-operation: any pulse in flight is dropped the next cycle.
- ena=0: FSM, counters, tgt and cur_step hold; xu = xd = 0.
  - A load strobe while ena=0 is ignored.
  - done is never asserted while ena=0.
- load (with ena=1): tgt <= min(target, MAX_STEP) at the clock edge. This is legal in any state except HOME.
- FSM states and transitions:
  - IDLE:
    - tgt > cur_step -> ISSUE_UP.
    - tgt < cur_step -> ISSUE_DN.
    - Otherwise stay in IDLE.
    - The decision uses the registered tgt, so a load takes effect the cycle after the strobe.
  - ISSUE_UP: xu=1 for exactly one cycle; cur_step += 1; load gap counter with max(gap,1); -> WAIT.
  - ISSUE_DN: xd=1 for exactly one cycle; cur_step -= 1; load gap counter; -> WAIT.
  - WAIT:
    - The gap counter decrements each cycle; at 1 it re-evaluates as IDLE does.
    - If cur_step == tgt at that point: done=1 for one cycle, -> IDLE.
    - Otherwise go directly to ISSUE_UP or ISSUE_DN.
    - Pulse period is therefore 1 + max(gap,1) cycles.
- Registered outputs: xu and xd are registered and never high together. cur_step never leaves 0..MAX_STEP.
- busy = (state != IDLE) or (tgt != cur_step).
  - busy rises the cycle after a load that changes the target.
  - busy falls in the same cycle as done.
- Retarget while busy: the new tgt is used at the next evaluation. Direction may reverse without an extra idle cycle beyond the normal gap.
  - If a retarget makes cur_step == tgt during WAIT, done still pulses at the end of WAIT.
- Load of a target equal to cur_step while IDLE: no pulses, no done, busy stays 0.
- gap changes are sampled only when entering WAIT.

Optional Feature:
PWM_SEQ_HOMING_EN
- Defined:
  - After reset the FSM enters HOME instead of IDLE, with busy=1.
  - HOME issues MAX_STEP xd pulses, each followed by the normal gap (gap sampled per pulse), forcing the generator to step 0 regardless of its prior state.
  - cur_step is forced to 0 at HOME exit; tgt = 0; -> IDLE; no done pulse.
  - load strobes during HOME are ignored.
  - ena=0 freezes HOME like any other state.
- Not defined: HOME state absent; reset behaviour exactly as above (cur_step = RESET_STEP, no pulses).

Test Plan:
- Reset then hold → after rst=1 for 2 cycles: cur_step=5, xu=xd=busy=done=0; with HOMING_EN, gap=1: 10 xd pulses, 2 cycles apart, then cur_step=0, busy=0.
- Step up → load target=8, gap=3: exactly 3 xu pulses, 4 cycles apart; cur_step 6,7,8; done one cycle after the final WAIT; no xd.
- Saturation and floor → load target=15: pulses stop at cur_step=10; then load target=0: exactly 10 xd pulses, cur_step=0, done once.
- Retarget reversal → from cur_step=5, load 9, then load 3 after the second xu (cur_step=7): 4 xd pulses follow, final cur_step=3, single done.
- ena freeze → drop ena for 20 cycles mid-WAIT with gap=5: no pulses and counters held; load ignored; resumes with the remaining gap count once ena returns.
- Reset mid-operation and gap=0 → rst asserted during ISSUE_UP: next cycle xu=0, cur_step=5; with gap=0, pulses appear every 2 cycles.

Source files
------------

// File: rtl/pwm_duty_sequencer_if.sv
// Bus between the control/register logic and the PWM duty sequencer.
//   ena      : run enable (shared with the PWM generator)
//   load     : one-cycle strobe that latches target
//   target   : requested duty step (saturated to MAX_STEP inside the sequencer)
//   gap      : idle cycles between consecutive step pulses (0 acts as 1)
//   xu / xd  : one-cycle increment / decrement pulses to the generator
//   busy     : mirror differs from target, or a sequence is in progress
//   cur_step : mirror of the generator's duty step
//   done     : one-cycle pulse when the mirror reaches the target
interface pwm_duty_sequencer_if #(
  parameter int unsigned GAP_W = 8
);
  logic             ena;
  logic             load;
  logic [3:0]       target;
  logic [GAP_W-1:0] gap;
  logic             xu;
  logic             xd;
  logic             busy;
  logic [3:0]       cur_step;
  logic             done;

  modport master (
    output ena, load, target, gap,
    input  xu, xd, busy, cur_step, done
  );

  modport slave (
    input  ena, load, target, gap,
    output xu, xd, busy, cur_step, done
  );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// PWM duty-step sequencer: walks the generator's duty step toward a latched
// target by issuing single-cycle xu/xd pulses spaced 1+max(gap,1) cycles
// apart, keeping a mirror of the generator's step count.
//
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : pwm_duty_sequencer_if.slave (ena, load, target, gap in;
//         xu, xd, busy, cur_step, done out)
//
// Optional build macro PWM_SEQ_HOMING_EN: after reset, drive MAX_STEP xd
// pulses to force the generator to step 0, then zero the mirror and target.
module pwm_duty_sequencer #(
  parameter int unsigned MAX_STEP   = 10,
  parameter int unsigned RESET_STEP = 5,
  parameter int unsigned GAP_W      = 8
) (
  input logic                 clk,
  input logic                 rst,
  pwm_duty_sequencer_if.slave bus
);

`ifdef PWM_SEQ_HOMING_EN
  typedef enum logic [2:0] {S_IDLE, S_ISSUE_UP, S_ISSUE_DN, S_WAIT, S_HOME} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ISSUE_UP, S_ISSUE_DN, S_WAIT} state_t;
`endif

  localparam logic [3:0] MAX_S = 4'(MAX_STEP);
  localparam logic [3:0] RST_S = 4'(RESET_STEP);

  state_t           state;
  logic [3:0]       tgt;
  logic [3:0]       cur;
  logic [GAP_W-1:0] cnt;
  logic             xu_q;
  logic             xd_q;
  logic             done_q;

  logic [3:0]       tgt_in;
  logic [GAP_W-1:0] gap_eff;
  logic             load_ok;
  state_t           eval_next;
  logic             eval_xu;
  logic             eval_xd;
  logic             eval_done;
  logic             eval_home_exit;

`ifdef PWM_SEQ_HOMING_EN
  logic       homing;
  logic [3:0] home_left;
  assign load_ok = bus.load & ~homing;
`else
  assign load_ok = bus.load;
`endif

  // Shared decision used by IDLE and at the end of each WAIT (and by HOME),
  // so a step-to-step reversal costs no extra cycle beyond the gap.
  always_comb begin
    tgt_in         = (bus.target > MAX_S) ? MAX_S : bus.target;
    gap_eff        = (bus.gap == '0) ? GAP_W'(1) : bus.gap;
    eval_next      = S_IDLE;
    eval_xu        = 1'b0;
    eval_xd        = 1'b0;
    eval_done      = 1'b0;
    eval_home_exit = 1'b0;
`ifdef PWM_SEQ_HOMING_EN
    if (homing) begin
      if (home_left != '0) begin
        eval_next = S_ISSUE_DN;
        eval_xd   = 1'b1;
      end else begin
        eval_home_exit = 1'b1;
      end
    end else
`endif
    if (tgt > cur) begin
      eval_next = S_ISSUE_UP;
      eval_xu   = 1'b1;
    end else if (tgt < cur) begin
      eval_next = S_ISSUE_DN;
      eval_xd   = 1'b1;
    end else begin
      eval_done = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      tgt    <= RST_S;
      cur    <= RST_S;
      cnt    <= '0;
      xu_q   <= 1'b0;
      xd_q   <= 1'b0;
      done_q <= 1'b0;
`ifdef PWM_SEQ_HOMING_EN
      homing    <= 1'b1;
      home_left <= MAX_S;
`endif
    end else if (bus.ena) begin
      xu_q   <= 1'b0;
      xd_q   <= 1'b0;
      done_q <= 1'b0;
      if (load_ok) tgt <= tgt_in;
      case (state)
        S_IDLE: begin
`ifdef PWM_SEQ_HOMING_EN
          if (homing) begin
            state <= S_HOME;
          end else
`endif
          begin
            state <= eval_next;
            xu_q  <= eval_xu;
            xd_q  <= eval_xd;
          end
        end
        S_ISSUE_UP: begin
          cur   <= cur + 4'd1;
          cnt   <= gap_eff;
          state <= S_WAIT;
        end
        S_ISSUE_DN: begin
`ifdef PWM_SEQ_HOMING_EN
          if (homing) home_left <= home_left - 4'd1;
          else        cur       <= cur - 4'd1;
`else
          cur <= cur - 4'd1;
`endif
          cnt   <= gap_eff;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt > GAP_W'(1)) begin
            cnt <= cnt - GAP_W'(1);
          end else begin
            cnt    <= '0;
            state  <= eval_next;
            xu_q   <= eval_xu;
            xd_q   <= eval_xd;
            done_q <= eval_done;
          end
        end
`ifdef PWM_SEQ_HOMING_EN
        S_HOME: begin
          state <= eval_next;
          xd_q  <= eval_xd;
        end
`endif
        default: state <= S_IDLE;
      endcase
`ifdef PWM_SEQ_HOMING_EN
      if ((state == S_HOME || state == S_WAIT) && eval_home_exit) begin
        cur    <= '0;
        tgt    <= '0;
        homing <= 1'b0;
      end
`else
      if (eval_home_exit) cur <= cur;
`endif
    end
  end

  // Pulse registers are held through ena=0 and masked at the output: the
  // generator shares ena, so an xu/xd held back here stays in step with it.
  assign bus.xu       = xu_q & bus.ena;
  assign bus.xd       = xd_q & bus.ena;
  assign bus.done     = done_q & bus.ena;
  assign bus.busy     = (state != S_IDLE) || (tgt != cur);
  assign bus.cur_step = cur;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
module tb_pwm_duty_sequencer;
  logic clk = 1'b0;
  logic rst;

  pwm_duty_sequencer_if #(.GAP_W(8)) bus ();

  pwm_duty_sequencer #(
    .MAX_STEP  (10),
    .RESET_STEP(5),
    .GAP_W     (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int cyc, n_xu, n_xd, n_done, n_busy, done_t;
  int both_hi = 0;
  int xu_t[$];
  int xd_t[$];
  logic [3:0] cur_at [0:63];

  task automatic clr_log();
    cyc = 0; n_xu = 0; n_xd = 0; n_done = 0; n_busy = 0; done_t = -1;
    xu_t.delete();
    xd_t.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.xu) begin n_xu++; xu_t.push_back(cyc); end
    if (bus.xd) begin n_xd++; xd_t.push_back(cyc); end
    if (bus.xu && bus.xd) both_hi++;
    if (bus.done) begin n_done++; done_t = cyc; end
    if (bus.busy) n_busy++;
    if (cyc < 64) cur_at[cyc] = bus.cur_step;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic strobe(input logic [3:0] t, input logic [7:0] g);
    bus.load = 1'b1; bus.target = t; bus.gap = g;
    step();
    bus.load = 1'b0;
  endtask

`ifdef PWM_SEQ_HOMING_EN
  task automatic settle_home();
    clr_log();
    run(30);
    bus.gap = 8'd1;
    strobe(4'd5, 8'd1);
    run(20);
  endtask
`endif

  task automatic test_reset();
    rst = 1'b1;
    run(2);
    tests++; if (bus.cur_step !== 4'd5) begin fails++; $display("FAIL reset_cur: got %0d want 5", bus.cur_step); end
    tests++; if (bus.xu !== 1'b0 || bus.xd !== 1'b0) begin fails++; $display("FAIL reset_pulses: xu=%b xd=%b want 0 0", bus.xu, bus.xd); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
    rst = 1'b0;
    clr_log();
`ifdef PWM_SEQ_HOMING_EN
    run(30);
    tests++; if (n_xd !== 10 || n_xu !== 0) begin fails++; $display("FAIL home_count: xd=%0d xu=%0d want 10 0", n_xd, n_xu); end
    tests++; if (xd_t[0] !== 2 || xd_t[9] - xd_t[0] !== 18) begin fails++; $display("FAIL home_spacing: first=%0d span=%0d want 2 18", xd_t[0], xd_t[9] - xd_t[0]); end
    tests++; if (bus.cur_step !== 4'd0 || bus.busy !== 1'b0 || n_done !== 0) begin fails++; $display("FAIL home_end: cur=%0d busy=%b done=%0d want 0 0 0", bus.cur_step, bus.busy, n_done); end
    bus.gap = 8'd1;
    strobe(4'd5, 8'd1);
    run(20);
`else
    run(6);
    tests++; if (n_xu !== 0 || n_xd !== 0 || n_busy !== 0 || n_done !== 0) begin fails++; $display("FAIL reset_hold: xu=%0d xd=%0d busy=%0d done=%0d want all 0", n_xu, n_xd, n_busy, n_done); end
`endif
    tests++; if (bus.cur_step !== 4'd5) begin fails++; $display("FAIL reset_settle: got %0d want 5", bus.cur_step); end
  endtask

  task automatic test_step_up();
    clr_log();
    strobe(4'd8, 8'd3);
    tests++; if (bus.busy !== 1'b1 || bus.xu !== 1'b0) begin fails++; $display("FAIL up_busy_rise: busy=%b xu=%b want 1 0", bus.busy, bus.xu); end
    run(19);
    tests++; if (n_xu !== 3 || n_xd !== 0) begin fails++; $display("FAIL up_count: xu=%0d xd=%0d want 3 0", n_xu, n_xd); end
    tests++; if (xu_t[0] !== 2 || xu_t[1] !== 6 || xu_t[2] !== 10) begin fails++; $display("FAIL up_times: %0d %0d %0d want 2 6 10", xu_t[0], xu_t[1], xu_t[2]); end
    tests++; if (cur_at[3] !== 4'd6 || cur_at[7] !== 4'd7 || cur_at[11] !== 4'd8) begin fails++; $display("FAIL up_mirror: %0d %0d %0d want 6 7 8", cur_at[3], cur_at[7], cur_at[11]); end
    tests++; if (n_done !== 1 || done_t !== 14) begin fails++; $display("FAIL up_done: n=%0d at=%0d want 1 14", n_done, done_t); end
    tests++; if (n_busy !== 13 || bus.busy !== 1'b0) begin fails++; $display("FAIL up_busy: cycles=%0d now=%b want 13 0", n_busy, bus.busy); end
  endtask

  task automatic test_noop();
    clr_log();
    strobe(4'd8, 8'd1);
    run(9);
    tests++; if (n_xu !== 0 || n_xd !== 0 || n_done !== 0 || n_busy !== 0) begin fails++; $display("FAIL noop: xu=%0d xd=%0d done=%0d busy=%0d want all 0", n_xu, n_xd, n_done, n_busy); end
  endtask

  task automatic test_saturate_floor();
    clr_log();
    strobe(4'd15, 8'd1);
    run(11);
    tests++; if (n_xu !== 2 || bus.cur_step !== 4'd10 || n_done !== 1 || done_t !== 6) begin fails++; $display("FAIL sat: xu=%0d cur=%0d done=%0d at=%0d want 2 10 1 6", n_xu, bus.cur_step, n_done, done_t); end
    clr_log();
    strobe(4'd0, 8'd1);
    run(29);
    tests++; if (n_xd !== 10 || n_xu !== 0) begin fails++; $display("FAIL floor_count: xd=%0d xu=%0d want 10 0", n_xd, n_xu); end
    tests++; if (xd_t[0] !== 2 || xd_t[9] !== 20) begin fails++; $display("FAIL floor_times: first=%0d last=%0d want 2 20", xd_t[0], xd_t[9]); end
    tests++; if (bus.cur_step !== 4'd0 || n_done !== 1 || done_t !== 22) begin fails++; $display("FAIL floor_end: cur=%0d done=%0d at=%0d want 0 1 22", bus.cur_step, n_done, done_t); end
  endtask

  task automatic test_retarget();
    strobe(4'd5, 8'd1);
    run(19);
    clr_log();
    strobe(4'd9, 8'd2);
    run(5);
    tests++; if (bus.cur_step !== 4'd7 || n_xu !== 2) begin fails++; $display("FAIL retgt_mid: cur=%0d xu=%0d want 7 2", bus.cur_step, n_xu); end
    strobe(4'd3, 8'd2);
    run(20);
    tests++; if (n_xd !== 4 || n_xu !== 2) begin fails++; $display("FAIL retgt_count: xd=%0d xu=%0d want 4 2", n_xd, n_xu); end
    tests++; if (xd_t[0] !== 8 || xd_t[3] !== 17) begin fails++; $display("FAIL retgt_times: first=%0d last=%0d want 8 17", xd_t[0], xd_t[3]); end
    tests++; if (bus.cur_step !== 4'd3 || n_done !== 1 || done_t !== 20) begin fails++; $display("FAIL retgt_end: cur=%0d done=%0d at=%0d want 3 1 20", bus.cur_step, n_done, done_t); end
  endtask

  task automatic test_ena_freeze();
    clr_log();
    strobe(4'd6, 8'd5);
    run(4);
    bus.ena = 1'b0; bus.load = 1'b1; bus.target = 4'd0;
    run(20);
    tests++; if (n_xu !== 1 || n_xd !== 0 || n_done !== 0 || bus.cur_step !== 4'd4) begin fails++; $display("FAIL freeze_hold: xu=%0d xd=%0d done=%0d cur=%0d want 1 0 0 4", n_xu, n_xd, n_done, bus.cur_step); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL freeze_busy: got %b want 1", bus.busy); end
    bus.ena = 1'b1; bus.load = 1'b0;
    run(20);
    tests++; if (n_xu !== 3 || xu_t[1] !== 28 || xu_t[2] !== 34) begin fails++; $display("FAIL freeze_resume: xu=%0d t1=%0d t2=%0d want 3 28 34", n_xu, xu_t[1], xu_t[2]); end
    tests++; if (bus.cur_step !== 4'd6 || n_done !== 1 || done_t !== 40) begin fails++; $display("FAIL freeze_end: cur=%0d done=%0d at=%0d want 6 1 40", bus.cur_step, n_done, done_t); end
  endtask

  task automatic test_reset_mid_gap0();
    clr_log();
    strobe(4'd9, 8'd0);
    step();
    tests++; if (bus.xu !== 1'b1) begin fails++; $display("FAIL mid_pre: xu=%b want 1", bus.xu); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (bus.xu !== 1'b0 || bus.cur_step !== 4'd5 || bus.busy !== 1'b0) begin fails++; $display("FAIL mid_reset: xu=%b cur=%0d busy=%b want 0 5 0", bus.xu, bus.cur_step, bus.busy); end
`ifdef PWM_SEQ_HOMING_EN
    settle_home();
`endif
    clr_log();
    strobe(4'd8, 8'd0);
    run(11);
    tests++; if (n_xu !== 3 || xu_t[0] !== 2 || xu_t[1] !== 4 || xu_t[2] !== 6) begin fails++; $display("FAIL gap0_times: n=%0d %0d %0d %0d want 3 2 4 6", n_xu, xu_t[0], xu_t[1], xu_t[2]); end
    tests++; if (bus.cur_step !== 4'd8 || n_done !== 1 || done_t !== 8) begin fails++; $display("FAIL gap0_end: cur=%0d done=%0d at=%0d want 8 1 8", bus.cur_step, n_done, done_t); end
  endtask

  task automatic test_exclusive();
    tests++; if (both_hi !== 0) begin fails++; $display("FAIL xu_xd_overlap: cycles=%0d want 0", both_hi); end
  endtask

  initial begin
    rst = 1'b1; bus.ena = 1'b1; bus.load = 1'b0; bus.target = 4'd0; bus.gap = 8'd1;
    test_reset();
    test_step_up();
    test_noop();
    test_saturate_floor();
    test_retarget();
    test_ena_freeze();
    test_reset_mid_gap0();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
